// File: rtl/sra32_pipe.sv
// Five-stage pipelined 32-bit right shifter (logical/arithmetic) with valid/ready on both sides.
// Optional rotate-right mode is enabled by defining SRA32_PIPE_ROTATE_EN.
module sra32_pipe #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [4:0]       in_shamt,
   input  logic             in_arith,
`ifdef SRA32_PIPE_ROTATE_EN
   input  logic             in_rot,
`endif
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   // Shift right by n when en is set; vacated MSBs take the fill bit, or the
   // bits shifted out of the LSB when rotating.
   function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] d, input logic en,
                                            input int n, input logic fill, input logic rot);
      logic [WIDTH-1:0] fillv;
      fillv = rot ? d : {WIDTH{fill}};
      return en ? ((d >> n) | (fillv << (WIDTH - n))) : d;
   endfunction

   logic stall, adv, rot_in;
   logic vld_p0, vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;
   logic [WIDTH-1:0] data_p0, data_p1, data_p2, data_p3, data_p4, data_p5;
   logic [TAG_W-1:0] tag_p0, tag_p1, tag_p2, tag_p3, tag_p4, tag_p5;
   logic [4:0] sh_p0;
   logic [3:0] sh_p1;
   logic [2:0] sh_p2;
   logic [1:0] sh_p3;
   logic       sh_p4;
   logic fill_p0, fill_p1, fill_p2, fill_p3, fill_p4;
   logic rot_p0, rot_p1, rot_p2, rot_p3, rot_p4;

`ifdef SRA32_PIPE_ROTATE_EN
   assign rot_in = in_rot;
`else
   assign rot_in = 1'b0;
`endif

   // All stages move in lockstep; a held output freezes the whole pipe.
   assign stall     = vld_p5 & ~out_ready;
   assign adv       = ~stall;
   assign in_ready  = ~stall;
   assign out_valid = vld_p5;
   assign out_data  = data_p5;
   assign out_tag   = tag_p5;
   assign busy      = vld_p0 | vld_p1 | vld_p2 | vld_p3 | vld_p4 | vld_p5;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         vld_p3 <= 1'b0;
         vld_p4 <= 1'b0;
         vld_p5 <= 1'b0;
      end else if (adv) begin
         vld_p0 <= in_valid;
         vld_p1 <= vld_p0;
         vld_p2 <= vld_p1;
         vld_p3 <= vld_p2;
         vld_p4 <= vld_p3;
         vld_p5 <= vld_p4;
      end
   end

   always_ff @(posedge clock) begin
      if (adv) begin
         // p0: capture operand, sample the fill bit once
         data_p0 <= in_data;
         sh_p0   <= in_shamt;
         fill_p0 <= in_arith & in_data[WIDTH-1];
         rot_p0  <= rot_in;
         tag_p0  <= in_tag;
         // p1: shift by 16
         data_p1 <= shr(data_p0, sh_p0[4], 16, fill_p0, rot_p0);
         sh_p1   <= sh_p0[3:0];
         fill_p1 <= fill_p0;
         rot_p1  <= rot_p0;
         tag_p1  <= tag_p0;
         // p2: shift by 8
         data_p2 <= shr(data_p1, sh_p1[3], 8, fill_p1, rot_p1);
         sh_p2   <= sh_p1[2:0];
         fill_p2 <= fill_p1;
         rot_p2  <= rot_p1;
         tag_p2  <= tag_p1;
         // p3: shift by 4
         data_p3 <= shr(data_p2, sh_p2[2], 4, fill_p2, rot_p2);
         sh_p3   <= sh_p2[1:0];
         fill_p3 <= fill_p2;
         rot_p3  <= rot_p2;
         tag_p3  <= tag_p2;
         // p4: shift by 2
         data_p4 <= shr(data_p3, sh_p3[1], 2, fill_p3, rot_p3);
         sh_p4   <= sh_p3[0];
         fill_p4 <= fill_p3;
         rot_p4  <= rot_p3;
         tag_p4  <= tag_p3;
      end
   end

   // p5: shift by 1; output register is cleared by reset so the port reads 0
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_p5 <= '0;
         tag_p5  <= '0;
      end else if (adv) begin
         data_p5 <= shr(data_p4, sh_p4, 1, fill_p4, rot_p4);
         tag_p5  <= tag_p4;
      end
   end

endmodule

// File: tb/tb_sra32_pipe.sv
// Directed self-checking bench for sra32_pipe: latency, shift results, streaming, stall and reset.
// Rotate checks are compiled in only when SRA32_PIPE_ROTATE_EN is defined.
module tb_sra32_pipe;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_arith = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic [4:0]  in_shamt = '0;
   logic [3:0]  in_tag = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] out_data;
   logic [3:0]  out_tag;
`ifdef SRA32_PIPE_ROTATE_EN
   logic        in_rot = 1'b0;
`endif

   int checks = 0;
   int errors = 0;
   int consumed = 0;
   logic [31:0] q_data[$];
   logic [3:0]  q_tag[$];

   localparam logic [31:0] EXP3 [8] = '{32'h8000_0000, 32'hC000_0000, 32'h2000_0000, 32'hF000_0000,
                                        32'h0800_0000, 32'hFC00_0000, 32'h0200_0000, 32'hFF00_0000};

   sra32_pipe #(.WIDTH(32), .TAG_W(4)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_arith(in_arith),
`ifdef SRA32_PIPE_ROTATE_EN
      .in_rot(in_rot),
`endif
      .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic consume();
      if (out_valid && out_ready) begin
         checks++;
         assert (q_data.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_output observed tag=%h expected no output", out_tag);
         end
         if (q_data.size() != 0) begin
            chk("stream_data", out_data, q_data.pop_front());
            chk("stream_tag", 32'(out_tag), 32'(q_tag.pop_front()));
            consumed++;
         end
      end
   endtask

   task automatic cycle(input logic rdy);
      @(negedge clock);
      out_ready = rdy;
      #1;
      consume();
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] sh, input logic ar,
                        input logic [3:0] tag, input logic [31:0] expd, input logic exp_rdy);
      in_valid = v;
      in_data  = d;
      in_shamt = sh;
      in_arith = ar;
      in_tag   = tag;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (v && exp_rdy) begin
         q_data.push_back(expd);
         q_tag.push_back(tag);
      end
   endtask

   task automatic single_op(input logic [31:0] d, input logic [4:0] sh, input logic ar,
                            input logic [3:0] tag, input logic [31:0] expd);
      @(negedge clock);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = d;
      in_shamt  = sh;
      in_arith  = ar;
      in_tag    = tag;
      #1;
      chk("single_in_ready", 32'(in_ready), 32'd1);
      for (int i = 1; i <= 5; i++) begin
         @(negedge clock);
         in_valid = 1'b0;
         chk("latency_not_yet", 32'(out_valid), 32'd0);
      end
      @(negedge clock);
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("single_data", out_data, expd);
      chk("single_tag", 32'(out_tag), 32'(tag));
      @(negedge clock);
      chk("single_drained", 32'(out_valid), 32'd0);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_tag", 32'(out_tag), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // single ops with latency check
      single_op(32'h8000_0000, 5'd4, 1'b1, 4'h1, 32'hF800_0000);
      single_op(32'h8000_0000, 5'd4, 1'b0, 4'h2, 32'h0800_0000);
      single_op(32'h1234_5678, 5'd0, 1'b1, 4'h3, 32'h1234_5678);
      single_op(32'hFFFF_FFFF, 5'd31, 1'b0, 4'h4, 32'h0000_0001);
      single_op(32'h8000_0000, 5'd31, 1'b1, 4'h5, 32'hFFFF_FFFF);
      single_op(32'h7FFF_FFFF, 5'd31, 1'b1, 4'h6, 32'h0000_0000);
      single_op(32'hF0F0_1234, 5'd13, 1'b1, 4'h7, 32'hFFFF_8780);
      single_op(32'hF0F0_1234, 5'd13, 1'b0, 4'h8, 32'h0007_8780);

      // eight back-to-back ops
      consumed = 0;
      for (int c = 0; c < 16; c++) begin
         cycle(1'b1);
         chk("stream_out_valid", 32'(out_valid), 32'((c >= 6 && c <= 13) ? 1 : 0));
         if (c < 8) drive(1'b1, 32'h8000_0000, 5'(c), c[0], 4'(c), EXP3[c], 1'b1);
         else       drive(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 1'b1);
      end
      chk("stream_count", 32'(consumed), 32'd8);

      // fill, stall three cycles, release
      consumed = 0;
      for (int c = 0; c < 25; c++) begin
         cycle((c >= 6 && c <= 8) ? 1'b0 : 1'b1);
         if (c < 6) begin
            drive(1'b1, 32'(32'h1111_1111 * (c + 1)), 5'd0, 1'b0, 4'(c + 1),
                  32'(32'h1111_1111 * (c + 1)), 1'b1);
         end else if (c <= 8) begin
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data", out_data, 32'h1111_1111);
            chk("stall_out_tag", 32'(out_tag), 32'd1);
            drive(1'b1, 32'h7777_7777, 5'd0, 1'b0, 4'h7, 32'h7777_7777, 1'b0);
         end else if (c == 9) begin
            drive(1'b1, 32'h7777_7777, 5'd0, 1'b0, 4'h7, 32'h7777_7777, 1'b1);
         end else begin
            drive(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 1'b1);
         end
      end
      chk("stall_count", 32'(consumed), 32'd7);
      chk("stall_queue_empty", 32'(q_data.size()), 32'd0);

      // reset with three ops in flight
      for (int c = 0; c < 3; c++) begin
         cycle(1'b1);
         drive(1'b1, 32'(32'h0000_0011 * (c + 1)), 5'd0, 1'b0, 4'(c + 1),
               32'(32'h0000_0011 * (c + 1)), 1'b1);
      end
      @(negedge clock);
      in_valid = 1'b0;
      chk("inflight_busy", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_out_data", out_data, 32'd0);
      chk("async_rst_out_tag", 32'(out_tag), 32'd0);
      q_data.delete();
      q_tag.delete();
      @(negedge clock);
      reset_n = 1'b1;
      consumed = 0;
      cycle(1'b1);
      drive(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 1'b1);
      cycle(1'b1);
      drive(1'b1, 32'hA5A5_0000, 5'd8, 1'b1, 4'hA, 32'hFFA5_A500, 1'b1);
      for (int c = 0; c < 12; c++) begin
         cycle(1'b1);
         drive(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 32'h0, 1'b1);
      end
      chk("post_rst_count", 32'(consumed), 32'd1);

`ifdef SRA32_PIPE_ROTATE_EN
      // rotate-right mode, arith ignored
      in_rot = 1'b1;
      single_op(32'h0000_00F1, 5'd4, 1'b0, 4'hB, 32'h1000_000F);
      single_op(32'h8000_00F1, 5'd4, 1'b1, 4'hC, 32'h1800_000F);
      in_rot = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
